// File: rtl/io_port_bank.sv
// Multi-channel I/O port bank for the Mini-SRC datapath: per-channel input FIFOs
// popped onto the bus, and per-channel output registers with a valid/ack handshake.
module io_port_bank #(
    parameter int DATA_W     = 32,
    parameter int N_IN       = 2,
    parameter int N_OUT      = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int IN_SEL_W  = (N_IN  > 1) ? $clog2(N_IN)  : 1,
    localparam int OUT_SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                    Clock,
    input  logic                    clear,
    input  logic [DATA_W-1:0]       BusMuxOut,
    input  logic                    InportOut,
    input  logic                    OutportIn,
    input  logic [IN_SEL_W-1:0]     in_sel,
    input  logic [OUT_SEL_W-1:0]    out_sel,
    output logic [DATA_W-1:0]       inport_data,
    input  logic [N_IN*DATA_W-1:0]  ext_in_data,
    input  logic [N_IN-1:0]         ext_in_valid,
    output logic [N_IN-1:0]         ext_in_ready,
    output logic [N_OUT*DATA_W-1:0] ext_out_data,
    output logic [N_OUT-1:0]        ext_out_valid,
    input  logic [N_OUT-1:0]        ext_out_ack,
    output logic [N_IN-1:0]         in_nonempty,
    output logic [N_IN-1:0]         underflow,
    output logic [N_OUT-1:0]        overrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic io_q, oo_q;
    logic pop_fire, wr_fire, in_sel_ok, out_sel_ok;

    logic [N_IN-1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [N_IN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]            push, pop, underflow_q, underflow_d;
    logic [DATA_W-1:0]          inport_q, inport_d;
    logic [DATA_W-1:0]          mem_q [N_IN][FIFO_DEPTH];

    logic [N_OUT-1:0][DATA_W-1:0] odata_q, odata_d;
    logic [N_OUT-1:0]             ovalid_q, ovalid_d, overrun_q, overrun_d, wr_ch;

    // Strobes may be held for a whole T-state; only the rising edge transfers.
    assign pop_fire   = InportOut & ~io_q;
    assign wr_fire    = OutportIn & ~oo_q;
    assign in_sel_ok  = {1'b0, in_sel}  < (IN_SEL_W + 1)'(N_IN);
    assign out_sel_ok = {1'b0, out_sel} < (OUT_SEL_W + 1)'(N_OUT);

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            ext_in_ready[i] = (cnt_q[i] != CNT_W'(FIFO_DEPTH));
            in_nonempty[i]  = (cnt_q[i] != '0);
        end
    end

    // NOTE: every signal gets a default before the loop so no latch is inferred.
    always_comb begin
        push        = '0;
        pop         = '0;
        underflow_d = underflow_q;
        inport_d    = inport_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        for (int i = 0; i < N_IN; i++) begin
            // Ready comes from the registered count, so a full channel refuses a
            // push even when a pop on the same edge frees a slot.
            push[i] = ext_in_valid[i] & ext_in_ready[i];
            if (pop_fire && in_sel_ok && in_sel == IN_SEL_W'(i)) begin
                if (in_nonempty[i]) begin
                    pop[i]   = 1'b1;
                    inport_d = mem_q[i][rd_ptr_q[i]];
                end else begin
                    underflow_d[i] = 1'b1;
                end
            end
            if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
            if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            if (push[i] && !pop[i])      cnt_d[i] = cnt_q[i] + 1'b1;
            else if (pop[i] && !push[i]) cnt_d[i] = cnt_q[i] - 1'b1;
        end
    end

    always_comb begin
        wr_ch     = '0;
        odata_d   = odata_q;
        ovalid_d  = ovalid_q;
        overrun_d = overrun_q;
        for (int j = 0; j < N_OUT; j++) begin
            wr_ch[j] = wr_fire & out_sel_ok & (out_sel == OUT_SEL_W'(j));
            if (wr_ch[j]) begin
                if (ovalid_q[j] && !ext_out_ack[j]) overrun_d[j] = 1'b1;
                odata_d[j]  = BusMuxOut;
                ovalid_d[j] = 1'b1;
            end else if (ovalid_q[j] && ext_out_ack[j]) begin
                ovalid_d[j] = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge Clock) begin
        if (clear) begin
            io_q        <= 1'b0;
            oo_q        <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            underflow_q <= '0;
            inport_q    <= '0;
            odata_q     <= '0;
            ovalid_q    <= '0;
            overrun_q   <= '0;
        end else begin
            io_q        <= InportOut;
            oo_q        <= OutportIn;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
            inport_q    <= inport_d;
            odata_q     <= odata_d;
            ovalid_q    <= ovalid_d;
            overrun_q   <= overrun_d;
        end
    end

    // NOTE: FIFO storage is not reset; zeroed counts make stale words unreachable.
    always_ff @(posedge Clock) begin
        for (int i = 0; i < N_IN; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= ext_in_data[i*DATA_W +: DATA_W];
        end
    end

    assign inport_data   = inport_q;
    assign ext_out_data  = odata_q;
    assign ext_out_valid = ovalid_q;
    assign underflow     = underflow_q;
    assign overrun       = overrun_q;

endmodule
